// File: rtl/lcd_bus_decoder.sv
// Passive HD44780 write-bus snooper: reassembles 4-bit nibbles into bytes,
// executes the command subset and shadows the 2x16 display text.
module lcd_bus_decoder (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic         lcd_e,
    input  logic [3:0]   lcd_d,
    output logic [127:0] row_top,
    output logic [127:0] row_bot,
    output logic [6:0]   ddram_addr,
    output logic         four_bit,
    output logic         byte_valid,
    output logic         byte_rs,
    output logic [7:0]   byte_data
);

    localparam int unsigned BUS_W  = 7;
    localparam int unsigned ROW_W  = 128;
    localparam int unsigned ADDR_W = 7;
    localparam logic [ROW_W-1:0] BLANK_ROW = {16{8'h20}};

    typedef enum logic {PH_HI, PH_LO} phase_t;

    // {rs, rw, e, d[3:0]} through a two-flop synchronizer
    logic [BUS_W-1:0] bus_meta;
    logic [BUS_W-1:0] bus_sync;
    logic             e_prev;
    phase_t           phase;
    logic [3:0]       hi_nib;
    logic             dir_up;
    logic             cgram_mode;

    logic             rs_s;
    logic             rw_s;
    logic             e_s;
    logic [3:0]       d_s;
    logic             accept;
    logic             done;
    logic [7:0]       asm_byte;
    logic [6:0]       col_lsb;

    assign rs_s    = bus_sync[6];
    assign rw_s    = bus_sync[5];
    assign e_s     = bus_sync[4];
    assign d_s     = bus_sync[3:0];
    assign accept  = e_prev & ~e_s & ~rw_s;
    // column 0 sits in the top byte of the row vector
    assign col_lsb = {~ddram_addr[3:0], 3'b000};

    // Byte assembly from the current nibble and any latched high nibble
    always_comb begin
        done     = 1'b0;
        asm_byte = 8'h00;
        if (accept) begin
            if (!four_bit) begin
                done     = 1'b1;
                asm_byte = {d_s, 4'h0};
            end else if (phase == PH_LO) begin
                done     = 1'b1;
                asm_byte = {hi_nib, d_s};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_meta   <= '0;
            bus_sync   <= '0;
            e_prev     <= 1'b0;
            phase      <= PH_HI;
            hi_nib     <= 4'h0;
            dir_up     <= 1'b1;
            cgram_mode <= 1'b0;
            row_top    <= BLANK_ROW;
            row_bot    <= BLANK_ROW;
            ddram_addr <= '0;
            four_bit   <= 1'b0;
            byte_valid <= 1'b0;
            byte_rs    <= 1'b0;
            byte_data  <= 8'h00;
        end else begin
            bus_meta   <= {lcd_rs, lcd_rw, lcd_e, lcd_d};
            bus_sync   <= bus_meta;
            e_prev     <= e_s;
            byte_valid <= done;

            if (accept && four_bit) begin
                if (phase == PH_HI) begin
                    hi_nib <= d_s;
                    phase  <= PH_LO;
                end else begin
                    phase  <= PH_HI;
                end
            end

            if (done) begin
                byte_rs   <= rs_s;
                byte_data <= asm_byte;
                if (!rs_s) begin
                    if (asm_byte[7:4] == 4'b0010) begin
                        four_bit <= 1'b1;
                        phase    <= PH_HI;
                    end
                    if (asm_byte[7]) begin
                        ddram_addr <= asm_byte[6:0];
                        cgram_mode <= 1'b0;
                    end else if (asm_byte[6]) begin
                        cgram_mode <= 1'b1;
                    end else if (asm_byte[7:1] == 7'b0000001) begin
                        ddram_addr <= '0;
                        cgram_mode <= 1'b0;
                    end else if (asm_byte == 8'h01) begin
                        row_top    <= BLANK_ROW;
                        row_bot    <= BLANK_ROW;
                        ddram_addr <= '0;
                        dir_up     <= 1'b1;
                        cgram_mode <= 1'b0;
                    end else if (asm_byte[7:2] == 6'b000001) begin
                        dir_up <= asm_byte[1];
                    end
                end else if (!cgram_mode) begin
                    // address advances even when outside both visible windows
                    if (ddram_addr[6:4] == 3'b000) begin
                        row_top[col_lsb +: 8] <= asm_byte;
                    end else if (ddram_addr[6:4] == 3'b100) begin
                        row_bot[col_lsb +: 8] <= asm_byte;
                    end
                    ddram_addr <= dir_up ? ddram_addr + ADDR_W'(1) : ddram_addr - ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/lcd_bus_decoder.md
# lcd_bus_decoder

Passive receiver for the HD44780-style character-LCD write bus driven by the lab LCD controller (LCD_RS, LCD_RW, LCD_E, LCD_D). It snoops the bus, reassembles 4-bit-mode nibbles into bytes, and executes the command subset the controller uses. It keeps a 2x16 shadow of display RAM in the same MSB-first string format the top level uses for `row`, so simulation and on-chip checkers read the displayed text directly.

## Interface
- No parameters.
- `clk`  in  1  system clock (100 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `lcd_rs`  in  1  register select (0 = command, 1 = data); asynchronous to `clk`.
- `lcd_rw`  in  1  read/write (1 = read); asynchronous.
- `lcd_e`  in  1  enable strobe; data latched on falling edge; asynchronous.
- `lcd_d`  in  4  data nibble; asynchronous.
- `row_top`  out  128  line 1 text; `[127:120]` = column 0, `[7:0]` = column 15.
- `row_bot`  out  128  line 2 text, same packing.
- `ddram_addr`  out  7  current address counter.
- `four_bit`  out  1  1 once the bus has entered 4-bit mode.
- `byte_valid`  out  1  one-cycle strobe per completed write byte.
- `byte_rs`  out  1  RS of that byte.
- `byte_data`  out  8  the completed byte.

## Operation
- All four bus inputs pass through a 2-flop synchronizer. `e_prev` holds the synchronized `lcd_e` delayed by one cycle. A fall event is `e_prev & ~e_sync`.
- On a fall event, the nibble and RS are taken from the synchronized copies.
- Fall events with synchronized `lcd_rw`=1 are ignored entirely: no byte and no phase change.
- 8-bit mode (reset state): each fall event forms byte `{lcd_d,4'h0}`. This handles the init nibbles 0x3, 0x3, 0x3, 0x2.
- 4-bit mode: the first fall event latches the high nibble (phase HI->LO). The second supplies the low nibble and completes the byte (phase LO->HI).
- Mode switch: a completed command byte with `byte[7:4]`=4'b0010 sets `four_bit`=1 and phase=HI. This covers 8-bit-mode 0x20 and 4-bit-mode 0x28. Once set, `four_bit` is cleared only by reset.
- Command decode (RS=0), priority top-down:
  - `1xxxxxxx`: `ddram_addr` = `byte[6:0]`; leave CGRAM mode.
  - `01xxxxxx`: enter CGRAM mode.
  - `0000001x`: `ddram_addr` = 0; leave CGRAM mode.
  - `00000001`: both rows = all 0x20; `ddram_addr` = 0; increment direction = +1; leave CGRAM mode.
  - `000001ix`: direction = `i` ? +1 : −1.
  - All others (display control, shift, function set): `byte_valid` only.
- Data write (RS=1):
  - In CGRAM mode: discarded; no address change.
  - Otherwise, if `ddram_addr` is 0x00–0x0F, write `row_top` column `addr`. If it is 0x40–0x4F, write `row_bot` column `addr−0x40`. Any other address writes nothing.
  - Then `ddram_addr` = `ddram_addr` ± 1 mod 128, in 7 bits: 0x7F+1 → 0x00 and 0x00−1 → 0x7F. The address moves even when the write was discarded for an out-of-window address.
- Reset values:
  - `row_top` and `row_bot` = {16{8'h20}}.
  - `ddram_addr` = 0.
  - `four_bit` = 0; phase = HI; direction = +1; CGRAM mode off.
  - `byte_valid` = 0, `byte_rs` = 0, `byte_data` = 0.
  - Synchronizer flops reset to 0.
- Reset mid-byte discards any pending high nibble.

## Timing
- Edge 0 is the first `clk` rising edge that samples `lcd_e` low.
- The fall event is combinational after edge 1.
- At edge 2, `byte_valid`, `byte_rs`, `byte_data`, the rows, `ddram_addr` and `four_bit` all update together. `byte_valid` is high for exactly one cycle.
- `lcd_e` high and low pulses must each be ≥3 `clk` cycles.
- `lcd_d` and `lcd_rs` must be stable from 3 cycles before to 1 cycle after the `lcd_e` fall.
- Bytes therefore complete at most once per 6 cycles, so there are no simultaneous events.
- `byte_valid` is registered. The row and address outputs are registered and change only at `byte_valid` edges.

## Test plan
- Reset -> rows all 0x20, `ddram_addr`=0, `four_bit`=0. Then send nibbles 3,3,3,2 (RS=0) -> four `byte_valid` pulses with data 0x30, 0x30, 0x30, 0x20, and `four_bit`=1 after the 4th.
- In 4-bit mode, send 0x28, 0x01, then data "Passwd" -> `row_top`[127:80]="Passwd", `ddram_addr`=6, `byte_data` sequence 0x28, 0x01, 0x50…
- Send 0xC0 then 16 data bytes "0123456789ABCDEF" -> `row_bot` equals that string, `ddram_addr`=0x50. One more byte leaves both rows unchanged and `ddram_addr`=0x51.
- Send 0x04 (decrement), 0x80, data 'X' -> `row_top` column 0='X', `ddram_addr`=0x7F (wrap). A following 0x06, 0xFF, data 'Y' -> `ddram_addr`=0x00, rows unchanged.
- Send 0x40, data 0x1F ×8, then 0x80, data 'Z' -> CGRAM data is discarded with `ddram_addr` unchanged; 'Z' lands at `row_top` column 0. Strobes with `lcd_rw`=1 interleaved -> no `byte_valid` and no phase shift.
- Assert `reset_n`=0 after a single high nibble in 4-bit mode -> all outputs return to reset values, and the next nibble is treated in 8-bit mode.
